// File: rtl/mpsoc_sysid_gate_pkg.sv
// Shared state encoding, sysid word addresses and sizing helper for the boot gate.
package mpsoc_sysid_gate_pkg;

   typedef enum logic [2:0] {
      SETTLE,
      RD_ID,
      RD_TS,
      CMP,
      RELEASE,
      PASS,
      FAIL
   } gate_state_t;

   localparam logic SYSID_ADDR_ID = 1'b0;
   localparam logic SYSID_ADDR_TS = 1'b1;

   // Bits needed to hold values 0..value-1 (returns 0 for value<=1).
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mpsoc_sysid_gate_stagger.sv
// Sequential CPU reset releaser: bit 0 on start, then one more bit every STAGGER_CYCLES.
module mpsoc_sysid_gate_stagger
   import mpsoc_sysid_gate_pkg::*;
#(
   parameter int N_CPUS         = 4,
   parameter int STAGGER_CYCLES = 8
)(
   input  logic              clock,
   input  logic              reset_n,
   input  logic              start,
   input  logic              clear,
   output logic [N_CPUS-1:0] release_mask,
   output logic              done
);

   localparam int CW = clog2(STAGGER_CYCLES + 1);
   localparam logic [N_CPUS-1:0] LSB_ONE = N_CPUS'(1);

   logic [CW-1:0]     gap_cnt_q;
   logic [N_CPUS-1:0] mask_q;
   logic              running;

   // The mask is a thermometer code, so the top bit alone marks completion.
   assign running      = (mask_q != '0) && !mask_q[N_CPUS-1];
   assign release_mask = mask_q;
   assign done         = mask_q[N_CPUS-1];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         mask_q    <= '0;
         gap_cnt_q <= '0;
      end else if (clear) begin
         mask_q    <= '0;
         gap_cnt_q <= '0;
      end else if (start) begin
         mask_q    <= LSB_ONE;
         gap_cnt_q <= '0;
      end else if (running) begin
         if (gap_cnt_q == CW'(STAGGER_CYCLES - 1)) begin
            gap_cnt_q <= '0;
            mask_q    <= (mask_q << 1) | LSB_ONE;
         end else begin
            gap_cnt_q <= gap_cnt_q + CW'(1);
         end
      end
   end

endmodule

// File: rtl/mpsoc_sysid_boot_gate.sv
// Reads sysid ID/timestamp over Avalon-MM, then releases CPU resets or latches failure.
// Optional read watchdog: define SYSID_GATE_TIMEOUT_EN.
module mpsoc_sysid_boot_gate
   import mpsoc_sysid_gate_pkg::*;
#(
   parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
   parameter logic [31:0] EXPECTED_TS    = 32'd1766574349,
   parameter int          N_CPUS         = 4,
   parameter int          SETTLE_CYCLES  = 16,
   parameter int          STAGGER_CYCLES = 8,
   parameter int          RETRY_MAX      = 3,
   parameter int          TIMEOUT_CYCLES = 255
)(
   input  logic              clock,
   input  logic              reset_n,
   output logic              avm_address,
   output logic              avm_read,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   input  logic              recheck,
   output logic [N_CPUS-1:0] cpu_reset_n,
   output logic              check_done,
   output logic              check_pass,
   output logic              check_fail,
   output logic [31:0]       id_seen,
   output logic [31:0]       ts_seen
);

   localparam int SW = clog2(SETTLE_CYCLES + 1);

   gate_state_t   state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic [3:0]    retry_q, retry_d;
   logic          read_q, read_d;
   logic          addr_q, addr_d;
   logic [31:0]   id_q, id_d, ts_q, ts_d;
   logic          done_q, done_d, pass_q, pass_d, fail_q, fail_d;
   logic          start_q, start_d;
   logic          stagger_clear, stagger_done;
   logic          attempt_ok;

`ifdef SYSID_GATE_TIMEOUT_EN
   localparam int TW = clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] to_cnt_q, to_cnt_d;
   logic          to_flag_q, to_flag_d;
`else
   // Timeout depth only matters when the read watchdog is built in.
   logic unused_timeout;
   assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= SETTLE;
         settle_q <= '0;
         retry_q  <= '0;
         read_q   <= 1'b0;
         addr_q   <= SYSID_ADDR_ID;
         id_q     <= '0;
         ts_q     <= '0;
         done_q   <= 1'b0;
         pass_q   <= 1'b0;
         fail_q   <= 1'b0;
         start_q  <= 1'b0;
`ifdef SYSID_GATE_TIMEOUT_EN
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         retry_q  <= retry_d;
         read_q   <= read_d;
         addr_q   <= addr_d;
         id_q     <= id_d;
         ts_q     <= ts_d;
         done_q   <= done_d;
         pass_q   <= pass_d;
         fail_q   <= fail_d;
         start_q  <= start_d;
`ifdef SYSID_GATE_TIMEOUT_EN
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
`endif
      end
   end

   always_comb begin
      state_d       = state_q;
      settle_d      = settle_q;
      retry_d       = retry_q;
      read_d        = read_q;
      addr_d        = addr_q;
      id_d          = id_q;
      ts_d          = ts_q;
      done_d        = done_q;
      pass_d        = pass_q;
      fail_d        = fail_q;
      start_d       = 1'b0;
      stagger_clear = 1'b0;
      attempt_ok    = (id_q == EXPECTED_ID) && (ts_q == EXPECTED_TS);
`ifdef SYSID_GATE_TIMEOUT_EN
      to_flag_d = to_flag_q;
      if (to_flag_q) attempt_ok = 1'b0;
`endif

      case (state_q)
         SETTLE: begin
            if (settle_q == SW'(SETTLE_CYCLES - 1)) begin
               settle_d = '0;
               state_d  = RD_ID;
               read_d   = 1'b1;
               addr_d   = SYSID_ADDR_ID;
            end else begin
               settle_d = settle_q + SW'(1);
            end
         end
         RD_ID: begin
            if (read_q && !avm_waitrequest) begin
               id_d    = avm_readdata;
               read_d  = 1'b0;
               state_d = RD_TS;
            end
`ifdef SYSID_GATE_TIMEOUT_EN
            else if (read_q && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               read_d    = 1'b0;
               to_flag_d = 1'b1;
               state_d   = CMP;
            end
`endif
         end
         RD_TS: begin
            // First RD_TS cycle is the idle gap between the two reads.
            if (!read_q) begin
               read_d = 1'b1;
               addr_d = SYSID_ADDR_TS;
            end else if (!avm_waitrequest) begin
               ts_d    = avm_readdata;
               read_d  = 1'b0;
               state_d = CMP;
            end
`ifdef SYSID_GATE_TIMEOUT_EN
            else if (to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
               read_d    = 1'b0;
               to_flag_d = 1'b1;
               state_d   = CMP;
            end
`endif
         end
         CMP: begin
            addr_d = SYSID_ADDR_ID;
`ifdef SYSID_GATE_TIMEOUT_EN
            to_flag_d = 1'b0;
`endif
            if (attempt_ok) begin
               state_d = RELEASE;
               start_d = 1'b1;
            end else if (retry_q < 4'(RETRY_MAX)) begin
               retry_d = retry_q + 4'd1;
               state_d = SETTLE;
            end else begin
               state_d = FAIL;
               done_d  = 1'b1;
               fail_d  = 1'b1;
            end
         end
         RELEASE: begin
            if (stagger_done) begin
               state_d = PASS;
               done_d  = 1'b1;
               pass_d  = 1'b1;
            end
         end
         PASS, FAIL: begin
            if (recheck) begin
               state_d       = SETTLE;
               settle_d      = '0;
               retry_d       = '0;
               done_d        = 1'b0;
               pass_d        = 1'b0;
               fail_d        = 1'b0;
               stagger_clear = 1'b1;
            end
         end
         default: state_d = SETTLE;
      endcase

`ifdef SYSID_GATE_TIMEOUT_EN
      // Counts stalled cycles of the current read; restarts on any state change.
      to_cnt_d = '0;
      if (read_q && avm_waitrequest && state_d == state_q) to_cnt_d = to_cnt_q + TW'(1);
`endif
   end

   mpsoc_sysid_gate_stagger #(
      .N_CPUS         (N_CPUS),
      .STAGGER_CYCLES (STAGGER_CYCLES)
   ) u_stagger (
      .clock        (clock),
      .reset_n      (reset_n),
      .start        (start_q),
      .clear        (stagger_clear),
      .release_mask (cpu_reset_n),
      .done         (stagger_done)
   );

   assign avm_read    = read_q;
   assign avm_address = addr_q;
   assign check_done  = done_q;
   assign check_pass  = pass_q;
   assign check_fail  = fail_q;
   assign id_seen     = id_q;
   assign ts_seen     = ts_q;

endmodule
